mv_seq_con: RTL
===============

# mv_seq_con

Sequential matrix-vector controller: y = M·x (+ b), optional ReLU, for a ROWS×COLS signed integer matrix held in the shared BRAM. It is the parametrised successor of the fixed 64×64 PE controller. It generalises matrix shape and BRAM layout, and adds bias and ReLU modes and a full result-vector write-back. It sits between the PS-visible BRAM port and the start/done control interface, and runs one MAC per cycle against a local copy of x.

## Interface
- DATA_WIDTH, 32: element, accumulator and BRAM word width (two's complement).
- ROWS, 64: matrix rows, i.e. result length (≥1).
- COLS, 64: matrix columns, i.e. x length (≥1).
- X_BASE, 0: word address of x[0].
- M_BASE, COLS: word address of M[0][0]. The matrix is stored row-major, so M[r][c] is at M_BASE + r·COLS + c.
- B_BASE, COLS+ROWS·COLS: word address of b[0].
- R_BASE, COLS+ROWS·COLS+ROWS: word address where y[0] is written.
- aclk  in  1  single clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in S_IDLE.
- mode_bias  in  1  sampled with an accepted start; when 1, b is added.
- mode_relu  in  1  sampled with an accepted start; when 1, negative results are written as 0.
- busy  out  1  high in every state except S_IDLE.
- done  out  1  one-cycle pulse in S_DONE.
- BRAM_ADDR  out  32  byte address = word address << 2.
- BRAM_WRDATA  out  32  write data.
- BRAM_WE  out  4  write enable: 4'hF only in S_WR, otherwise 0.
- BRAM_CLK  out  1  equal to aclk (pass-through).
- BRAM_RDDATA  in  32  read data. Data for the address driven in cycle t is valid in cycle t+1.

## Operation
- States: S_IDLE, S_LDX, S_LDX_DR, S_ROW, S_DRAIN, S_WR, S_DONE.
- S_IDLE: when start is high, latch the mode bits, clear the row counter r and go to S_LDX.
  - start is ignored in every other state.
- S_LDX: COLS cycles. Cycle k drives X_BASE+k. The returned word is written to the local x buffer, x_buf[k], one cycle later.
- S_LDX_DR: one cycle; it captures x_buf[COLS-1]. Next state is S_ROW.
- S_ROW: issues COLS+b reads, where b = mode_bias.
  - If b=1, B_BASE+r is issued first.
  - Then M_BASE+r·COLS+c is issued for c = 0..COLS-1.
- Accumulator, on each returned word (during S_ROW cycles 2.. and S_DRAIN):
  - The bias word loads acc directly.
  - Matrix word c updates acc ← (acc or 0 for the first term) + M·x_buf[c].
  - The product and the sum are truncated to DATA_WIDTH bits (wrap, no saturation).
- S_DRAIN: one cycle; it consumes the last returned word.
- S_WR: one cycle.
  - BRAM_ADDR = R_BASE+r and BRAM_WE = 4'hF.
  - BRAM_WRDATA = (mode_relu && acc[MSB]) ? 0 : acc.
  - If r == ROWS-1, go to S_DONE; otherwise increment r and go to S_ROW.
- S_DONE: one cycle with done=1, then S_IDLE.
- Outside S_WR, BRAM_WRDATA holds its last written value. BRAM_ADDR is 0 in S_IDLE, S_DRAIN and S_DONE.
- Reset (any state, including mid-row):
  - The next state is S_IDLE and there is no done pulse.
  - BRAM_WE is 0 from the reset cycle onward, so no partial result is written.
  - x_buf contents are don't-care; they are reloaded on the next start.

## Timing
- Reset values: busy=0, done=0, BRAM_WE=0, BRAM_ADDR=0, BRAM_WRDATA=0, internal acc=0, r=0.
- start accepted in cycle 0 gives:
  - S_LDX in cycles 1..COLS.
  - S_LDX_DR in cycle COLS+1.
  - Row r starting at cycle COLS+2 + r·T, where T = COLS+2+b.
- y[r] is written in cycle COLS+2 + (r+1)·T − 1.
- done is high in cycle COLS+2 + ROWS·T; busy falls in the same cycle that S_IDLE is re-entered.
- Back-to-back operation: start in the cycle after done (S_IDLE) is accepted. start held high through S_DONE is not accepted until S_IDLE.
- COLS=1: S_ROW lasts 1+b cycles, and the accumulator logic handles first term = last term.

## Test plan
- ROWS=COLS=4, M=identity, x=[1,2,3,4], no modes.
  - Writes 1,2,3,4 to R_BASE..R_BASE+3, with WE pulses at cycles 11,17,23,29.
  - done at cycle 30.
- Same shape, M all −1, x=[1,1,1,1], b=[10,0,3,5], mode_bias=1.
  - With mode_relu=0: writes 6, 0xFFFFFFFC, 0xFFFFFFFF, 1.
  - With mode_relu=1: writes 6, 0, 0, 1.
  - done at cycle 34.
- Wrap: COLS=4, row of 0x40000000, x all 1 → writes 0x00000000.
- start pulsed during S_ROW and during S_DONE → no restart, single done. start in the following S_IDLE cycle → second run completes with identical results.
- areset asserted for one cycle mid-S_ROW of row 2.
  - No WE for row 2 and no done; busy=0 next cycle.
  - A fresh start reproduces the full correct result vector.
- ROWS=3, COLS=1, x=[−2], M=[1,2,3] → writes −2, −4, −6 (0xFFFFFFFE, 0xFFFFFFFC, 0xFFFFFFFA); done at cycle 3+3·3=12.

Source files
------------

// File: rtl/mv_seq_con.sv
// mv_seq_con: sequential y = M*x (+b) controller with optional ReLU.
// Loads x locally, then runs one MAC per cycle per row and writes y back to BRAM.
module mv_seq_con #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 64,
    parameter int COLS       = 64,
    parameter int X_BASE     = 0,
    parameter int M_BASE     = COLS,
    parameter int B_BASE     = COLS + ROWS * COLS,
    parameter int R_BASE     = COLS + ROWS * COLS + ROWS
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    input  logic                  mode_bias,
    input  logic                  mode_relu,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           BRAM_ADDR,
    output logic [DATA_WIDTH-1:0] BRAM_WRDATA,
    output logic [3:0]            BRAM_WE,
    output logic                  BRAM_CLK,
    input  logic [DATA_WIDTH-1:0] BRAM_RDDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDX,
        S_LDX_DR,
        S_ROW,
        S_DRAIN,
        S_WR,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        K_NONE,
        K_X,
        K_B,
        K_M
    } kind_e;

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int XN = 1 << CW;

    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [31:0]   X_B    = 32'(X_BASE);
    localparam logic [31:0]   M_B    = 32'(M_BASE);
    localparam logic [31:0]   B_B    = 32'(B_BASE);
    localparam logic [31:0]   R_B    = 32'(R_BASE);
    localparam logic [31:0]   C_N    = 32'(COLS);

    state_e                state_q, state_d;
    logic [RW-1:0]         r_q, r_d;
    logic [CW-1:0]         c_q, c_d;
    logic [31:0]           mrow_q, mrow_d;
    logic                  bias_q, bias_d;
    logic                  relu_q, relu_d;
    logic [31:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    kind_e                 iss_kind_q, iss_kind_d;
    logic [CW-1:0]         iss_col_q, iss_col_d;
    kind_e                 rd_kind_q, rd_kind_d;
    logic [CW-1:0]         rd_col_q, rd_col_d;
    logic [DATA_WIDTH-1:0] x_buf_q [XN];
    logic [DATA_WIDTH-1:0] prod;
    logic                  row_go;

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        c_d        = c_q;
        mrow_d     = mrow_q;
        bias_d     = bias_q;
        relu_d     = relu_q;
        addr_d     = '0;
        wdat_d     = wdat_q;
        we_d       = 1'b0;
        acc_d      = acc_q;
        iss_kind_d = K_NONE;
        iss_col_d  = '0;
        rd_kind_d  = iss_kind_q;
        rd_col_d   = iss_col_q;
        row_go     = 1'b0;
        prod       = BRAM_RDDATA * x_buf_q[rd_col_q];

        // rd_* tags the word arriving this cycle (issued one cycle earlier)
        unique case (rd_kind_q)
            K_B:     acc_d = BRAM_RDDATA;
            K_M:     acc_d = ((rd_col_q == '0 && !bias_q) ? '0 : acc_q) + prod;
            default: ;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LDX;
                    bias_d     = mode_bias;
                    relu_d     = mode_relu;
                    r_d        = '0;
                    c_d        = '0;
                    mrow_d     = M_B;
                    addr_d     = X_B;
                    iss_kind_d = K_X;
                end
            end
            S_LDX: begin
                if (c_q == C_LAST) begin
                    state_d = S_LDX_DR;
                end else begin
                    c_d        = c_q + CW'(1);
                    addr_d     = X_B + 32'(c_d);
                    iss_kind_d = K_X;
                    iss_col_d  = c_d;
                end
            end
            S_LDX_DR: row_go = 1'b1;
            S_ROW: begin
                if (iss_kind_q == K_B) begin
                    addr_d     = mrow_q;
                    iss_kind_d = K_M;
                end else if (c_q == C_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    c_d        = c_q + CW'(1);
                    addr_d     = mrow_q + 32'(c_d);
                    iss_kind_d = K_M;
                    iss_col_d  = c_d;
                end
            end
            S_DRAIN: begin
                state_d = S_WR;
                addr_d  = R_B + 32'(r_q);
                we_d    = 1'b1;
                wdat_d  = (relu_q && acc_d[DATA_WIDTH-1]) ? '0 : acc_d;
            end
            S_WR: begin
                if (r_q == R_LAST) begin
                    state_d = S_DONE;
                end else begin
                    r_d    = r_q + RW'(1);
                    mrow_d = mrow_q + C_N;
                    row_go = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (row_go) begin
            state_d = S_ROW;
            c_d     = '0;
            if (bias_q) begin
                addr_d     = B_B + 32'(r_d);
                iss_kind_d = K_B;
            end else begin
                addr_d     = mrow_d;
                iss_kind_d = K_M;
            end
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            mrow_q     <= '0;
            bias_q     <= 1'b0;
            relu_q     <= 1'b0;
            addr_q     <= '0;
            wdat_q     <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            acc_q      <= '0;
            iss_kind_q <= K_NONE;
            iss_col_q  <= '0;
            rd_kind_q  <= K_NONE;
            rd_col_q   <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            mrow_q     <= mrow_d;
            bias_q     <= bias_d;
            relu_q     <= relu_d;
            addr_q     <= addr_d;
            wdat_q     <= wdat_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            acc_q      <= acc_d;
            iss_kind_q <= iss_kind_d;
            iss_col_q  <= iss_col_d;
            rd_kind_q  <= rd_kind_d;
            rd_col_q   <= rd_col_d;
        end
    end

    // x_buf is reloaded on every start, so it needs no reset
    always_ff @(posedge aclk) begin
        if (rd_kind_q == K_X) begin
            x_buf_q[rd_col_q] <= BRAM_RDDATA;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign BRAM_ADDR   = addr_q << 2;
    assign BRAM_WRDATA = wdat_q;
    assign BRAM_WE     = (we_q && !areset) ? 4'hF : 4'h0;
    assign BRAM_CLK    = aclk;

endmodule
